soc_mem2_arbiter: RTL

SOC_MEM2_ARBITER -- requirements
Module: soc_mem2_arbiter

---
 rtl/soc_mem2_arbiter_pkg.sv | 16 +
 rtl/rr_arb2.sv | 15 +
 rtl/soc_mem2_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/soc_mem2_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package soc_mem2_arbiter_pkg;

   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_BE_W    = DEF_DATA_W / 8;
   localparam int GRANT_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2,
      ST_FROZEN = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision. last_grant=1 means m1 won the previous
// contest, so m0 takes the next tie. A lone requester always wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant, purely combinational
   always_comb begin
      grant[0] = req[0] & (~req[1] | last_grant);
      grant[1] = req[1] & (~req[0] | ~last_grant);
   end

endmodule

// File: rtl/soc_mem2_arbiter.sv
// Two-requester arbiter in front of a fixed-latency-1 synchronous memory.
// Grant is decided combinationally each cycle; read data returns one cycle
// later and is steered by a registered owner tag (state_q) plus valid bit.
// Optional build macro SOC_MEM2_ARBITER_STATS_EN adds saturating grant counters.
//
// state     | meaning
// ----------|-----------------------------------------------
// ST_IDLE   | no grant issued this cycle
// ST_GRANT0 | m0 granted this cycle
// ST_GRANT1 | m1 granted this cycle
// ST_FROZEN | freeze high, no grants issued
//
// The registered state therefore names the owner of the access issued in
// the previous cycle, which is exactly the owner of returning read data.
module soc_mem2_arbiter
   import soc_mem2_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DEF_BE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
`ifdef SOC_MEM2_ARBITER_STATS_EN
   ,
   output logic [GRANT_CNT_W-1:0] m0_grant_cnt,
   output logic [GRANT_CNT_W-1:0] m1_grant_cnt
`endif
);

   logic [1:0] pending;
   logic [1:0] req_eff;
   logic [1:0] grant;
   logic       last_grant;
   logic       rd_vld_q;
   arb_state_t state_q;
   arb_state_t state_d;

   // read+write together counts as a write, so only the write flag matters below
   assign pending = {m1_read | m1_write, m0_read | m0_write};
   // reset is folded in so waitrequest stays high while reset is held
   assign req_eff = pending & {2{~freeze & ~reset}};

   rr_arb2 u_rr_arb2 (
      .req        (req_eff),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode from this cycle's grant
   always_comb begin
      state_d = ST_IDLE;
      if (freeze)        state_d = ST_FROZEN;
      else if (grant[0]) state_d = ST_GRANT0;
      else if (grant[1]) state_d = ST_GRANT1;
   end

   // Requester handshakes and memory-side mux
   always_comb begin
      m0_waitrequest   = ~grant[0];
      m1_waitrequest   = ~grant[1];
      mem_chipselect   = |grant;
      mem_write        = (grant[0] & m0_write) | (grant[1] & m1_write);
      mem_address      = grant[1] ? m1_address    : m0_address;
      mem_byteenable   = grant[1] ? m1_byteenable : m0_byteenable;
      mem_writedata    = grant[1] ? m1_writedata  : m0_writedata;
      mem_clken        = ~freeze;
      m0_readdata      = mem_readdata;
      m1_readdata      = mem_readdata;
      m0_readdatavalid = rd_vld_q & (state_q == ST_GRANT0);
      m1_readdatavalid = rd_vld_q & (state_q == ST_GRANT1);
   end

   // Round-robin history and read-return valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         rd_vld_q   <= 1'b0;
      end else begin
         if (|grant) last_grant <= grant[1];
         rd_vld_q <= (grant[0] & ~m0_write) | (grant[1] & ~m1_write);
      end
   end

`ifdef SOC_MEM2_ARBITER_STATS_EN
   // Saturating per-requester grant counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_grant_cnt <= '0;
         m1_grant_cnt <= '0;
      end else begin
         if (grant[0] && (m0_grant_cnt != '1)) m0_grant_cnt <= m0_grant_cnt + 1'b1;
         if (grant[1] && (m1_grant_cnt != '1)) m1_grant_cnt <= m1_grant_cnt + 1'b1;
      end
   end
`else
   // grant statistics not built
`endif

endmodule
